tick_enable_gen: RTL and testbench
==================================

Name: tick_enable_gen

Overview:
- Programmable tick/enable generator that sits directly upstream of the team's enable-gated counters.
- Divides clk by a programmable period and emits single-cycle tick strobes for the downstream counter's enable input.
- Supports periodic (free-running) and one-shot burst modes, with start/stop control, busy/done status and a running tick count.

Parameters:
- CNT_W, 16, width of the period prescaler and the tick counter.
- BURST_W, 8, width of the one-shot burst length.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- stop  input  1  end operation; sampled only in RUN.
- mode  input  1  0 = periodic, 1 = one-shot burst; latched at start.
- period  input  CNT_W  clk cycles per tick; latched at start.
- burst_len  input  BURST_W  ticks per one-shot burst; latched at start.
- tick  output  1  single-cycle enable strobe to the downstream counter.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse on one-shot completion or stop.
- tick_cnt  output  CNT_W  ticks issued since the last start.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port rst. rst is sampled on the clk posedge only; there is no asynchronous path.
- Reset values: state=IDLE, tick=0, busy=0, done=0, tick_cnt=0, prescaler=0, burst counter=0.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 latches mode, period and burst_len; clears prescaler and tick_cnt; goes to RUN. busy=1 from the next cycle.
  - RUN: prescaler increments every cycle.
    - When prescaler == eff_period-1: tick=1 for one cycle, prescaler returns to 0, tick_cnt increments.
    - eff_period = (period==0) ? 1 : period.
  - Leaving RUN: always returns to IDLE, with done=1 for one cycle and busy=0 in that same cycle.
- Latency: start sampled at edge k gives tick high in cycles k+P, k+2P, ... (P = eff_period). P=1 gives tick every cycle starting at k+1.
- One-shot: after the tick numbered eff_burst (eff_burst = (burst_len==0) ? 1 : burst_len), the next cycle has done=1, busy=0, state=IDLE.
- Periodic: runs until stop. tick_cnt wraps modulo 2^CNT_W and is not saturated.
- stop and a tick in the same cycle: the tick is still issued and counted, then the block goes to IDLE with a done pulse.
- stop and the final one-shot tick in the same cycle: exactly one done pulse.
- start while busy: ignored; the latched values are unchanged.
- start and stop both high in IDLE: start wins; stop is ignored in IDLE.
- Input changes during RUN: changes to period, mode or burst_len have no effect until the next start.
- tick_cnt holds its final value in IDLE until the next start.
- rst mid-RUN: at the next edge all state returns to reset values. No done pulse, and no tick in that cycle.

Decomposition:
- Shared package tick_gen_pkg:
  - state_t enum {IDLE, RUN}.
  - mode_t enum {PERIODIC=0, ONESHOT=1}.
  - Default CNT_W/BURST_W constants.
- Sub-module tick_prescaler (CNT_W):
  - Inputs: clk, rst, clr, en, eff_period.
  - Output: wrap strobe.
  - The top level holds the FSM, burst counter and tick_cnt.

Test Plan:
- Reset: rst=1 for 3 cycles, then release; nothing else driven -> tick=busy=done=0, tick_cnt=0, no activity for 20 cycles.
- Periodic: period=3, mode=0, start at cycle 0, stop at cycle 10 -> tick at cycles 3, 6, 9; done at cycle 11; tick_cnt=3.
- One-shot: period=2, burst_len=4, mode=1 -> ticks at cycles 2, 4, 6, 8; done at cycle 9; busy low from 9; tick_cnt=4.
- Edge values: period=0 -> tick every cycle from cycle 1. burst_len=0 in one-shot -> exactly 1 tick, then done.
- Simultaneity: stop coincident with tick #2 (period=4) -> tick issued, tick_cnt=2, single done pulse. start while busy -> no restart and period unchanged.
- Reset mid-run: rst asserted at cycle 5 of period=2 periodic -> all outputs 0 at the next edge, no done pulse. A new start afterwards behaves as a fresh run.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and default widths for the tick/enable generator.
package tick_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Period prescaler: counts 0..eff_period-1 while enabled, strobes on the last count.
module tick_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_eff_period,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;

  // The wrap strobe is combinational off the count; the top registers it as the tick.
  assign o_wrap = i_en && (r_cnt == (i_eff_period - CNT_W'(1)));

  // Count up while enabled, return to zero on wrap; clr restarts the period.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : (r_cnt + CNT_W'(1));
    end
  end

endmodule

// File: rtl/tick_enable_gen.sv
// Programmable tick/enable generator: periodic or one-shot burst of single-cycle ticks.
module tick_enable_gen
  import tick_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   tick_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  mode_t              r_mode;
  logic [CNT_W-1:0]   r_eff_period;
  logic [BURST_W-1:0] r_eff_burst;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               r_tick;
  logic               r_busy;
  logic               r_done;

  logic               w_start;
  logic               w_finish;
  logic               w_burst_done;
  logic               w_pre_en;
  logic               w_wrap;

  // A finished burst holds the prescaler so no extra tick slips out on the exit cycle.
  assign w_burst_done = (r_state == RUN) && (r_mode == ONESHOT) &&
                        (r_burst_cnt == r_eff_burst);
  assign w_pre_en     = (r_state == RUN) && !w_burst_done;

  tick_prescaler #(.CNT_W(CNT_W)) u_pre (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (w_start),
    .i_en         (w_pre_en),
    .i_eff_period (r_eff_period),
    .o_wrap       (w_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: start only seen in IDLE, stop/burst completion only in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop || w_burst_done) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch run configuration at start; zero period/length are treated as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= PERIODIC;
      r_eff_period <= CNT_W'(1);
      r_eff_burst  <= BURST_W'(1);
    end else if (w_start) begin
      r_mode       <= mode_t'(mode);
      r_eff_period <= (period == '0) ? CNT_W'(1) : period;
      r_eff_burst  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
    end
  end

  // Registered outputs and counters; a tick coincident with stop is still counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tick_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_tick <= w_wrap;
      r_done <= w_finish;
      r_busy <= (w_state_nxt == RUN);
      if (w_start) begin
        r_tick_cnt  <= '0;
        r_burst_cnt <= '0;
      end else if (w_wrap) begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        if (r_mode == ONESHOT) r_burst_cnt <= r_burst_cnt + BURST_W'(1);
      end
    end
  end

  assign tick     = r_tick;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_tick_enable_gen.sv
// Bench for tick_enable_gen: vector table, corner sequences, random vs reference model.
module tb_tick_enable_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  burst_len = '0;
  logic        tick, busy, done;
  logic [15:0] tick_cnt;
  logic        tick4, busy4, done4;
  logic [3:0]  cnt4;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  tick_enable_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .burst_len(burst_len),
    .tick(tick), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  // Narrow instance used to see the tick counter wrap quickly.
  tick_enable_gen #(.CNT_W(4), .BURST_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period[3:0]), .burst_len(burst_len[2:0]),
    .tick(tick4), .busy(busy4), .done(done4), .tick_cnt(cnt4)
  );

  typedef struct {
    logic        st, sp, md;
    logic [15:0] per;
    logic [7:0]  bl;
    logic        t, b, d;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[$];

  // Apply one cycle of inputs, then settle just after the edge.
  task automatic cyc(input logic rs, st, sp, md, input logic [15:0] per, input logic [7:0] bl);
    rst = rs; start = st; stop = sp; mode = md; period = per; burst_len = bl;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic expo(input string nm, input logic t, b, d, input logic [15:0] c);
    chk(nm, {13'd0, tick, busy, done, tick_cnt}, {13'd0, t, b, d, c});
  endtask

  // Reference model state
  logic        m_run, m_os, et, ed;
  logic [15:0] m_cnt;
  int          m_el, m_P, m_B, m_iss;
  logic        rs_r, st_r, sp_r, md_r;
  logic [15:0] per_r;
  logic [7:0]  bl_r;

  initial begin
    // Reset and quiet idle
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      expo("reset", 0, 0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      expo("idle_quiet", 0, 0, 0, 0);
    end

    // Periodic P=3 with an ignored restart, stop, stop-in-idle ignored
    tbl.push_back('{1,0,0,3,0, 0,1,0,0});
    tbl.push_back('{0,0,0,0,0, 0,1,0,0});
    tbl.push_back('{0,0,0,0,0, 0,1,0,0});
    tbl.push_back('{0,0,0,0,0, 1,1,0,1});
    tbl.push_back('{0,0,0,0,0, 0,1,0,1});
    tbl.push_back('{1,0,0,7,0, 0,1,0,1});
    tbl.push_back('{0,0,0,0,0, 1,1,0,2});
    tbl.push_back('{0,0,0,0,0, 0,1,0,2});
    tbl.push_back('{0,0,0,0,0, 0,1,0,2});
    tbl.push_back('{0,0,0,0,0, 1,1,0,3});
    tbl.push_back('{0,0,0,0,0, 0,1,0,3});
    tbl.push_back('{0,1,0,0,0, 0,0,1,3});
    tbl.push_back('{0,0,0,0,0, 0,0,0,3});
    tbl.push_back('{0,1,0,0,0, 0,0,0,3});
    // One-shot P=2 B=4 with mid-run input changes ignored
    tbl.push_back('{1,0,1,2,4, 0,1,0,0});
    tbl.push_back('{0,0,0,5,1, 0,1,0,0});
    tbl.push_back('{0,0,0,0,0, 1,1,0,1});
    tbl.push_back('{0,0,0,0,0, 0,1,0,1});
    tbl.push_back('{0,0,0,0,0, 1,1,0,2});
    tbl.push_back('{0,0,0,0,0, 0,1,0,2});
    tbl.push_back('{0,0,0,0,0, 1,1,0,3});
    tbl.push_back('{0,0,0,0,0, 0,1,0,3});
    tbl.push_back('{0,0,0,0,0, 1,1,0,4});
    tbl.push_back('{0,0,0,0,0, 0,0,1,4});
    tbl.push_back('{0,0,0,0,0, 0,0,0,4});
    // start+stop in IDLE: start wins; P=1 then stop on a tick
    tbl.push_back('{1,1,0,1,0, 0,1,0,0});
    tbl.push_back('{0,0,0,0,0, 1,1,0,1});
    tbl.push_back('{0,1,0,0,0, 1,0,1,2});
    tbl.push_back('{0,0,0,0,0, 0,0,0,2});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(0, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].per, tbl[i].bl);
      expo($sformatf("vec%0d", i), tbl[i].t, tbl[i].b, tbl[i].d, tbl[i].c);
    end

    // period=0 behaves as 1
    cyc(0, 1, 0, 0, 0, 0); expo("p0_start", 0, 1, 0, 0);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 0, 0, 0, 0); expo("p0_tick", 1, 1, 0, 16'(n));
    end
    cyc(0, 0, 1, 0, 0, 0); expo("p0_stop", 1, 0, 1, 5);
    cyc(0, 0, 0, 0, 0, 0); expo("p0_hold", 0, 0, 0, 5);

    // burst_len=0 gives exactly one tick
    cyc(0, 1, 0, 1, 3, 0); expo("b0_start", 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("b0_wait", 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("b0_wait", 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("b0_tick", 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expo("b0_done", 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0); expo("b0_idle", 0, 0, 0, 1);

    // stop coincident with tick #2, P=4
    cyc(0, 1, 0, 0, 4, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("st2_tick1", 1, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); expo("st2_stop", 1, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0); expo("st2_after", 0, 0, 0, 2);

    // stop on the final one-shot tick: single done
    cyc(0, 1, 0, 1, 2, 2);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("osf_tick1", 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); expo("osf_stop", 1, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0); expo("osf_after", 0, 0, 0, 2);

    // reset mid-run, then a fresh run
    cyc(0, 1, 0, 0, 2, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("rm_tick2", 1, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 0); expo("rm_rst", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("rm_nodone", 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 2, 0); expo("rm_fresh0", 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("rm_fresh1", 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); expo("rm_fresh2", 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 0); expo("rm_stop", 0, 0, 1, 1);

    // tick counter wraps (4-bit instance) after 17 ticks
    cyc(0, 1, 0, 0, 1, 0);
    repeat (17) cyc(0, 0, 0, 0, 0, 0);
    chk("wrap4_cnt", {28'd0, cnt4}, 32'd1);
    chk("wrap16_cnt", {16'd0, tick_cnt}, 32'd17);
    cyc(0, 0, 1, 0, 0, 0);
    chk("wrap4_done", {31'd0, done4}, 32'd1);

    // Random stimulus against the reference model
    cyc(1, 0, 0, 0, 0, 0);
    m_run = 0; m_cnt = 0; m_os = 0; m_el = 0; m_P = 1; m_B = 1; m_iss = 0;
    for (int i = 0; i < 3000; i++) begin
      rs_r  = ($urandom_range(0, 199) == 0);
      st_r  = ($urandom_range(0, 7) == 0);
      sp_r  = ($urandom_range(0, 39) == 0);
      md_r  = 1'($urandom_range(0, 1));
      per_r = 16'($urandom_range(0, 5));
      bl_r  = 8'($urandom_range(0, 5));
      et = 0; ed = 0;
      if (rs_r) begin
        m_run = 0; m_cnt = 0;
      end else if (!m_run) begin
        if (st_r) begin
          m_run = 1; m_el = 0; m_iss = 0; m_cnt = 0; m_os = md_r;
          m_P = (per_r == 0) ? 1 : int'(per_r);
          m_B = (bl_r == 0) ? 1 : int'(bl_r);
        end
      end else begin
        m_el++;
        if (m_os && m_iss == m_B) begin
          ed = 1; m_run = 0;
        end else begin
          if (m_el % m_P == 0) begin et = 1; m_iss++; m_cnt++; end
          if (sp_r) begin ed = 1; m_run = 0; end
        end
      end
      cyc(rs_r, st_r, sp_r, md_r, per_r, bl_r);
      expo("rand", et, m_run, ed, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
